gpio_bus_arbiter: RTL and testbench
===================================

Name: gpio_bus_arbiter

Overview:
- Shares the single register port of the 64-pin GPIO controller between the two cores of the MAKu MCU (requester 0 = core 0, requester 1 = core 1).
- Arbitrates round-robin and sequences each transaction onto the GPIO register bus.
- Provides atomic bit-set and bit-clear operations per request.
- Keeps shadow copies of the two data-output registers so set/clear on pin outputs never depends on sampled pin inputs.

Parameters:
- DATA_W, 32, register data width; must match the GPIO register bus.
- ADDR_W, 4, register address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- c0_req / c1_req  in  1  request; held high until the matching ack
- c0_op / c1_op  in  2  operation: 00 read, 01 write, 10 set bits, 11 clear bits
- c0_addr / c1_addr  in  ADDR_W  GPIO register address
- c0_wdata / c1_wdata  in  DATA_W  write data or bit mask
- c0_ack / c1_ack  out  1  one-cycle completion pulse
- c0_rdata / c1_rdata  out  DATA_W  result; valid only while the matching ack is high
- c0_err / c1_err  out  1  error flag; valid only while the matching ack is high
- reg_en  out  1  GPIO register access strobe
- reg_we  out  1  GPIO write enable
- reg_addr  out  ADDR_W  GPIO address
- reg_wdata  out  DATA_W  GPIO write data
- reg_rdata  in  DATA_W  GPIO read data; valid the cycle after a read strobe
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. All outputs 0, shadow_a = shadow_b = 0, last_grant = 1 (so requester 0 wins first). Reset mid-transaction abandons it immediately with no ack.
- Bus outputs are decoded from registered state and latched fields only; there is no combinational path from cN_* inputs to reg_*.
- Grant (IDLE):
  - One requesting: it is granted.
  - Both requesting: the one not equal to last_grant is granted.
  - On grant, op/addr/wdata are latched and last_grant is updated.
  - A requester's fields are sampled only in its grant cycle.
- States: IDLE, RD, RCAP, WR, ACK.
  - RD: reg_en=1, reg_we=0.
  - RCAP: reg_en=0; reg_rdata captured into rdata_q.
  - WR: reg_en=1, reg_we=1, reg_wdata = computed value.
  - ACK: the granted requester's ack=1; next state is IDLE.
- Sequences by op and address (cycle 0 = grant cycle in IDLE):
  - Read, addr 0x0–0x7: IDLE→RD→RCAP→ACK. Ack in cycle 3, rdata = rdata_q.
  - Write, addr 0x0–0x7: IDLE→WR→ACK. Ack in cycle 2, rdata = 0.
  - Set/clear, addr 0x1,0x2,0x5,0x6: IDLE→RD→RCAP→WR→ACK. Write value is rdata_q|wdata (set) or rdata_q&~wdata (clear). Ack in cycle 4, rdata = old value.
  - Set/clear, addr 0x0/0x4: no read. IDLE→WR→ACK, write value computed from shadow_a/shadow_b. Ack in cycle 2, rdata = old shadow value.
  - Clear, addr 0x3/0x7 (W1C status): IDLE→WR→ACK, writes wdata unmodified.
  - Set, addr 0x3/0x7: IDLE→ACK, no bus access, err=1.
  - Any op, addr 0x8–0xF: IDLE→ACK, no bus access, err=1, rdata = 0.
- Shadows: every WR to addr 0x0 loads shadow_a with reg_wdata; every WR to addr 0x4 loads shadow_b. Updated in the WR cycle.
- Ack handshake:
  - Requester drops req in the cycle after ack.
  - If req is still high in the IDLE cycle after ACK, it is a new request.
  - Minimum spacing between grants is the ACK→IDLE cycle.
- Fairness: with both requesters continuously active, grants strictly alternate.
- Only one transaction is in flight; the set/clear read-modify-write cannot be interleaved by the other core.

Test Plan:
- Reset, then c0 write addr 0x1 data 0x0000_00FF: reg_en=reg_we=1, reg_addr=1 in cycle 1; c0_ack in cycle 2, c0_err=0, busy low in cycle 3.
- c1 read addr 0x1 with GPIO returning 0x0000_00FF: reg_en=1, reg_we=0 in cycle 1; c1_ack in cycle 3 with c1_rdata=0x0000_00FF.
- c0 and c1 req in the same cycle after reset: c0 granted first, then c1; repeated 4 times, grants alternate 0,1,0,1.
- c0 write 0x0 = 0xA5A5_0000, then c1 set addr 0x0 mask 0x0000_000F: no read strobe; write of 0xA5A5_000F; c1_rdata=0xA5A5_0000.
- c0 clear addr 0x2 mask 0x1 with int_en=0x3: sequence RD, RCAP, WR; write of 0x2; ack in cycle 4. Then c1 set addr 0x7 and read addr 0xA: each acks in cycle 1 with err=1 and no reg_en.
- Assert rst_n low during the RCAP of a set op: outputs 0 asynchronously, no ack issued, shadows cleared, first grant after release goes to c0.

Source files
------------

// File: rtl/gpio_bus_arbiter_if.sv
// Two-core request ports plus GPIO register bus for gpio_bus_arbiter.
// slave: arbiter side; master: cores and GPIO controller side.
interface gpio_bus_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              c0_req;
  logic              c1_req;
  logic [1:0]        c0_op;
  logic [1:0]        c1_op;
  logic [ADDR_W-1:0] c0_addr;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic [DATA_W-1:0] c1_wdata;
  logic              c0_ack;
  logic              c1_ack;
  logic [DATA_W-1:0] c0_rdata;
  logic [DATA_W-1:0] c1_rdata;
  logic              c0_err;
  logic              c1_err;
  logic              reg_en;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;

  modport slave (
    input  c0_req, c1_req, c0_op, c1_op,
    input  c0_addr, c1_addr, c0_wdata, c1_wdata,
    input  reg_rdata,
    output c0_ack, c1_ack, c0_rdata, c1_rdata,
    output c0_err, c1_err,
    output reg_en, reg_we, reg_addr, reg_wdata,
    output busy
  );

  modport master (
    output c0_req, c1_req, c0_op, c1_op,
    output c0_addr, c1_addr, c0_wdata, c1_wdata,
    output reg_rdata,
    input  c0_ack, c1_ack, c0_rdata, c1_rdata,
    input  c0_err, c1_err,
    input  reg_en, reg_we, reg_addr, reg_wdata,
    input  busy
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin sharing of the GPIO register port between two cores,
// with atomic set/clear. Ports: clk, rst_n, bus (slave modport).
module gpio_bus_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  gpio_bus_arbiter_if.slave bus
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_SET = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD, RCAP, WR, ACK
  } state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              last_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] sh_a_q;
  logic [DATA_W-1:0] sh_b_q;
  logic              en_q;
  logic              we_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [DATA_W-1:0] rwd_q;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rdo_q;
  logic              busy_q;

  logic              gnt_c;
  logic [1:0]        op_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wd_c;
  logic [1:0]        lo_c;
  logic              bad_c;
  logic              shd_c;
  logic [DATA_W-1:0] sh_c;
  logic [DATA_W-1:0] wv_c;
  logic [DATA_W-1:0] rmw_c;

  always_comb begin
    gnt_c = (bus.c0_req && bus.c1_req) ? ~last_q
                                       : bus.c1_req;
    op_c   = gnt_c ? bus.c1_op    : bus.c0_op;
    addr_c = gnt_c ? bus.c1_addr  : bus.c0_addr;
    wd_c   = gnt_c ? bus.c1_wdata : bus.c0_wdata;
    lo_c   = addr_c[1:0];
    bad_c  = (addr_c > ADDR_W'(7)) ||
             (op_c == OP_SET && lo_c == 2'b11);
    // set/clear on data-out regs works from the shadow
    shd_c  = op_c[1] && lo_c == 2'b00;
    sh_c   = addr_c[2] ? sh_b_q : sh_a_q;
    wv_c   = wd_c;
    if (shd_c)
      wv_c = (op_c == OP_SET) ? (sh_c | wd_c)
                              : (sh_c & ~wd_c);
    rmw_c  = (op_q == OP_SET) ? (bus.reg_rdata | wdata_q)
                              : (bus.reg_rdata & ~wdata_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      rwd_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdo_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      rwd_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdo_q   <= '0;
      busy_q  <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.c0_req || bus.c1_req) begin
            gnt_q   <= gnt_c;
            last_q  <= gnt_c;
            op_q    <= op_c;
            addr_q  <= addr_c;
            wdata_q <= wd_c;
            rdata_q <= shd_c ? sh_c : '0;
            if (bad_c) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else if (op_c == OP_RD ||
                         (op_c[1] && (lo_c[0] ^ lo_c[1]))) begin
              state_q <= RD;
              en_q    <= 1'b1;
              raddr_q <= addr_c;
            end else begin
              state_q <= WR;
              en_q    <= 1'b1;
              we_q    <= 1'b1;
              raddr_q <= addr_c;
              rwd_q   <= wv_c;
              if (addr_c == ADDR_W'(0)) sh_a_q <= wv_c;
              if (addr_c == ADDR_W'(4)) sh_b_q <= wv_c;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        RD: state_q <= RCAP;
        RCAP: begin
          rdata_q <= bus.reg_rdata;
          if (op_q == OP_RD) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            rdo_q   <= bus.reg_rdata;
          end else begin
            state_q <= WR;
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            raddr_q <= addr_q;
            rwd_q   <= rmw_c;
          end
        end
        WR: begin
          state_q <= ACK;
          ack_q   <= 1'b1;
          rdo_q   <= rdata_q;
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reg_en    = en_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_addr  = raddr_q;
  assign bus.reg_wdata = rwd_q;
  assign bus.busy      = busy_q;
  assign bus.c0_ack    = ack_q & ~gnt_q;
  assign bus.c1_ack    = ack_q & gnt_q;
  assign bus.c0_err    = err_q & ~gnt_q;
  assign bus.c1_err    = err_q & gnt_q;
  assign bus.c0_rdata  = gnt_q ? '0 : rdo_q;
  assign bus.c1_rdata  = gnt_q ? rdo_q : '0;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed and random transactions
// against a transaction-level model of the arbiter and GPIO regs.
module tb_gpio_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpio_bus_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  gpio_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          who;
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [31:0] wd;
    int          lat;
    bit          err;
    logic [31:0] rd;
    int          nrd;
    int          nwr;
    logic [31:0] wv;
    int          start;
    int          grd;
    int          gwr;
  } txn_t;

  txn_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          dropq[2];
  logic        env_clr;
  logic [31:0] env_mem[8];
  logic [31:0] m_mem[8];
  logic [31:0] pins;
  logic [31:0] m_sha;
  logic [31:0] m_shb;
  int          m_last;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // GPIO controller: data-out regs read back pin inputs,
  // addr 3/7 are write-one-to-clear
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 8; i++) env_mem[i] <= '0;
      bus.reg_rdata <= '0;
    end else if (bus.reg_en) begin
      if (bus.reg_we) begin
        if (bus.reg_addr[1:0] == 2'b11)
          env_mem[bus.reg_addr[2:0]] <=
            env_mem[bus.reg_addr[2:0]] & ~bus.reg_wdata;
        else
          env_mem[bus.reg_addr[2:0]] <= bus.reg_wdata;
      end else begin
        bus.reg_rdata <= (bus.reg_addr[1:0] == 2'b00) ?
          pins : env_mem[bus.reg_addr[2:0]];
      end
    end
  end

  function automatic txn_t model(int who, logic [1:0] op,
                                 logic [3:0] a,
                                 logic [31:0] d);
    txn_t t;
    logic [31:0] old;
    logic [31:0] v;
    bit w1c;
    bit sh;
    t.who = who; t.op = op; t.addr = a; t.wd = d;
    t.lat = 1; t.err = 1; t.rd = '0;
    t.nrd = 0; t.nwr = 0; t.wv = '0;
    t.start = 0; t.grd = 0; t.gwr = 0;
    w1c = (a == 3 || a == 7);
    sh  = (a == 0 || a == 4);
    if (a > 7 || (op == 2 && w1c)) return t;
    t.err = 0;
    if (op == 0) begin
      t.lat = 3;
      t.nrd = 1;
      t.rd = sh ? pins : m_mem[a[2:0]];
      return t;
    end
    if (op == 1 || w1c) begin
      v = d;
    end else begin
      if (sh) old = (a == 0) ? m_sha : m_shb;
      else old = m_mem[a[2:0]];
      v = (op == 2) ? (old | d) : (old & ~d);
      t.rd = old;
      if (!sh) t.nrd = 1;
    end
    t.nwr = 1;
    t.wv = v;
    t.lat = 2 + 2 * t.nrd;
    if (a == 0) m_sha = v;
    if (a == 4) m_shb = v;
    if (w1c) m_mem[a[2:0]] = m_mem[a[2:0]] & ~v;
    else m_mem[a[2:0]] = v;
    return t;
  endfunction

  task automatic step();
    int w;
    @(posedge clk);
    #1;
    cyc++;
    if (dropq[0]) begin bus.c0_req = 1'b0; dropq[0] = 0; end
    if (dropq[1]) begin bus.c1_req = 1'b0; dropq[1] = 0; end
    if (bus.reg_en) begin
      if (q.size() == 0) begin
        chk("stray_en", 32'(bus.reg_en), 0);
      end else if (bus.reg_we) begin
        q[0].gwr++;
        chk("waddr", 32'(bus.reg_addr), 32'(q[0].addr));
        chk("wdata", bus.reg_wdata, q[0].wv);
        chk("wcyc", cyc - q[0].start, q[0].lat - 1);
      end else begin
        q[0].grd++;
        chk("raddr", 32'(bus.reg_addr), 32'(q[0].addr));
        chk("rcyc", cyc - q[0].start, 1);
      end
    end
    if (bus.c0_ack || bus.c1_ack) begin
      w = bus.c1_ack ? 1 : 0;
      if (q.size() == 0) begin
        chk("stray_ack", 1, 0);
      end else begin
        chk("ack_excl", 32'(bus.c0_ack & bus.c1_ack), 0);
        chk("who", w, q[0].who);
        chk("lat", cyc - q[0].start, q[0].lat);
        chk("err", 32'(w ? bus.c1_err : bus.c0_err),
            32'(q[0].err));
        chk("rdata", w ? bus.c1_rdata : bus.c0_rdata, q[0].rd);
        chk("nrd", q[0].grd, q[0].nrd);
        chk("nwr", q[0].gwr, q[0].nwr);
        chk("busy_ack", 32'(bus.busy), 1);
        dropq[w] = 1;
        void'(q.pop_front());
        if (q.size() > 0) q[0].start = cyc + 1;
      end
    end
    // fields must not matter once granted
    if (q.size() > 0 && cyc == q[0].start + 1) begin
      if (q[0].who == 0) begin
        bus.c0_op = 2'($urandom);
        bus.c0_addr = 4'($urandom);
        bus.c0_wdata = $urandom;
      end else begin
        bus.c1_op = 2'($urandom);
        bus.c1_addr = 4'($urandom);
        bus.c1_wdata = $urandom;
      end
    end
  endtask

  task automatic go(bit e0, bit e1,
                    logic [1:0] o0, logic [3:0] a0,
                    logic [31:0] d0,
                    logic [1:0] o1, logic [3:0] a1,
                    logic [31:0] d1);
    int first;
    int n;
    if (e0) begin
      bus.c0_op = o0; bus.c0_addr = a0;
      bus.c0_wdata = d0; bus.c0_req = 1'b1;
    end
    if (e1) begin
      bus.c1_op = o1; bus.c1_addr = a1;
      bus.c1_wdata = d1; bus.c1_req = 1'b1;
    end
    if (e0 && e1) first = (m_last == 0) ? 1 : 0;
    else first = e1 ? 1 : 0;
    if (first == 0) q.push_back(model(0, o0, a0, d0));
    else q.push_back(model(1, o1, a1, d1));
    m_last = first;
    if (e0 && e1) begin
      if (first == 0) q.push_back(model(1, o1, a1, d1));
      else q.push_back(model(0, o0, a0, d0));
      m_last = 1 - first;
    end
    q[0].start = cyc;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      chk("timeout", q.size(), 0);
      q.delete();
      bus.c0_req = 1'b0;
      bus.c1_req = 1'b0;
    end
    step();
    step();
    chk("busy_idle", 32'(bus.busy), 0);
  endtask

  task automatic rnd_fields(output logic [1:0] o,
                            output logic [3:0] a,
                            output logic [31:0] d);
    o = 2'($urandom);
    if ($urandom_range(0, 3) == 0) a = 4'($urandom);
    else a = 4'($urandom_range(0, 7));
    d = $urandom;
  endtask

  initial begin
    logic [1:0]  o0, o1;
    logic [3:0]  a0, a1;
    logic [31:0] d0, d1;
    int mode;
    bus.c0_req = 1'b0; bus.c1_req = 1'b0;
    bus.c0_op = '0; bus.c1_op = '0;
    bus.c0_addr = '0; bus.c1_addr = '0;
    bus.c0_wdata = '0; bus.c1_wdata = '0;
    dropq[0] = 0; dropq[1] = 0;
    env_clr = 1'b1;
    pins = $urandom | 32'h8000_0001;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_sha = '0; m_shb = '0; m_last = 1;
    repeat (3) @(posedge clk);
    #1;
    env_clr = 1'b0;
    chk("rst_en", 32'(bus.reg_en), 0);
    chk("rst_we", 32'(bus.reg_we), 0);
    chk("rst_addr", 32'(bus.reg_addr), 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", 32'({bus.c0_ack, bus.c1_ack}), 0);
    chk("rst_err", 32'({bus.c0_err, bus.c1_err}), 0);
    chk("rst_rdata", bus.c0_rdata | bus.c1_rdata, 0);
    rst_n = 1'b1;
    step();

    go(1, 0, 2'd1, 4'h1, 32'h0000_00FF, 2'd0, 4'h0, 0);
    go(0, 1, 2'd0, 4'h0, 0, 2'd0, 4'h1, 0);
    repeat (4)
      go(1, 1, 2'd1, 4'h1, $urandom, 2'd1, 4'h5, $urandom);
    go(1, 0, 2'd1, 4'h0, 32'hA5A5_0000, 2'd0, 4'h0, 0);
    go(0, 1, 2'd0, 4'h0, 0, 2'd2, 4'h0, 32'h0000_000F);
    go(1, 0, 2'd1, 4'h2, 32'h3, 2'd0, 4'h0, 0);
    go(1, 0, 2'd3, 4'h2, 32'h1, 2'd0, 4'h0, 0);
    go(0, 1, 2'd0, 4'h0, 0, 2'd2, 4'h7, 32'h1);
    go(0, 1, 2'd0, 4'h0, 0, 2'd0, 4'hA, 0);
    go(0, 1, 2'd0, 4'h0, 0, 2'd0, 4'h0, 0);

    // reset while a set is in its capture cycle
    bus.c0_op = 2'd2; bus.c0_addr = 4'h1;
    bus.c0_wdata = 32'hF0; bus.c0_req = 1'b1;
    @(posedge clk); #1;
    chk("mr_rd_en", 32'(bus.reg_en), 1);
    @(posedge clk); #1;
    chk("mr_rcap_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_en", 32'(bus.reg_en), 0);
    bus.c0_req = 1'b0;
    m_sha = '0; m_shb = '0; m_last = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("mr_ack", 32'({bus.c0_ack, bus.c1_ack}), 0);
    rst_n = 1'b1;
    go(1, 1, 2'd2, 4'h0, 32'h0000_0F00,
             2'd2, 4'h4, 32'h0000_00F0);

    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 2);
      rnd_fields(o0, a0, d0);
      rnd_fields(o1, a1, d1);
      go(mode != 1, mode != 0, o0, a0, d0, o1, a1, d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
